// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared constants and helpers for the SAP T-state sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

  // Default maximum number of T-states per instruction
  localparam int STATES_DEFAULT = 10;

  // Binary indices of the named T-states
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  // Out-of-range lengths (zero or above the maximum) fall back to full length
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned states);
    return ((len == 0) || (len > states)) ? states : len;
  endfunction

endpackage : sap_pkg
`default_nettype wire

// File: rtl/onehot_decode.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_decode
//  Description : Binary index to one-hot decoder, bit0 corresponds to index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_decode #(
  parameter  int N  = 10,
  localparam int IW = $clog2(N)
) (
  input  logic [IW-1:0] i_idx,
  output logic [N-1:0]  o_onehot
);

  // One comparator per output bit; exactly one bit matches a legal index
  for (genvar g = 0; g < N; g++) begin : g_bit
    assign o_onehot[g] = (i_idx == IW'(g));
  end

endmodule : onehot_decode
`default_nettype wire

// File: rtl/t_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : t_state_sequencer
//  Description : Parametrised T-state generator with enable, per-instruction
//                cycle length, early end-of-instruction and sticky halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module t_state_sequencer
  import sap_pkg::*;
#(
  parameter  int STATES = STATES_DEFAULT,
  localparam int IW     = $clog2(STATES)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              EN,
  input  logic              HLT,
  input  logic              RUN,
  input  logic              LEN_LD,
  input  logic [IW:0]       LEN,
  input  logic              NXT,
  output logic [STATES-1:0] state,
  output logic [IW-1:0]     t_idx,
  output logic              last,
  output logic              cycle_done,
  output logic              halted
);

  localparam int LW = IW + 1;

  logic [IW-1:0] r_t_idx;
  logic [LW-1:0] r_len_q;
  logic          r_halted;
  logic          r_cycle_done;

  logic [LW-1:0] w_len_clamp;
  logic [LW-1:0] w_lim;
  logic [LW-1:0] w_idx_ext;
  logic          w_adv;
  logic          w_at_lim;
  logic          w_wrap;

  assign w_len_clamp = LW'(clamp_len(32'(LEN), STATES));
  assign w_lim       = LEN_LD ? w_len_clamp : r_len_q;
  assign w_idx_ext   = {1'b0, r_t_idx};

  // A freshly loaded length shorter than the elapsed count also wraps, so the
  // index can never run past the limit.
  assign w_at_lim = ((w_idx_ext + LW'(1)) >= w_lim);
  assign w_wrap   = NXT | w_at_lim;

  // A halt request blocks advancing on the very edge it is sampled
  assign w_adv = EN & ~r_halted & ~HLT;

  // Sticky halt: HLT has priority over RUN when both are asserted
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_halted <= 1'b0;
    end else if (HLT) begin
      r_halted <= 1'b1;
    end else if (RUN) begin
      r_halted <= 1'b0;
    end
  end

  // Index, stored length and wrap pulse; a wrap restores full length for fetch
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_t_idx      <= '0;
      r_len_q      <= LW'(STATES);
      r_cycle_done <= 1'b0;
    end else if (w_adv) begin
      if (w_wrap) begin
        r_t_idx      <= '0;
        r_len_q      <= LW'(STATES);
        r_cycle_done <= 1'b1;
      end else begin
        r_t_idx      <= r_t_idx + IW'(1);
        r_cycle_done <= 1'b0;
        if (LEN_LD) begin
          r_len_q <= w_len_clamp;
        end
      end
    end else begin
      r_cycle_done <= 1'b0;
    end
  end

  onehot_decode #(
    .N (STATES)
  ) u_onehot_decode (
    .i_idx    (r_t_idx),
    .o_onehot (state)
  );

  assign t_idx      = r_t_idx;
  assign cycle_done = r_cycle_done;
  assign halted     = r_halted;
  assign last       = ~r_halted & ((w_idx_ext == (w_lim - LW'(1))) | NXT);

endmodule : t_state_sequencer
`default_nettype wire

// File: tb/tb_t_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t_state_sequencer
//  Description : Directed self-checking bench for t_state_sequencer, STATES=6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t_state_sequencer;
  import sap_pkg::*;

  localparam int STATES = 6;
  localparam int IW     = $clog2(STATES);

  logic              CLK = 1'b0;
  logic              CLR, EN, HLT, RUN, LEN_LD, NXT;
  logic [IW:0]       LEN;
  logic [STATES-1:0] state;
  logic [IW-1:0]     t_idx;
  logic              last, cycle_done, halted;

  int n_vec = 0;
  int n_err = 0;
  int exp_idx;

  t_state_sequencer #(
    .STATES (STATES)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .EN         (EN),
    .HLT        (HLT),
    .RUN        (RUN),
    .LEN_LD     (LEN_LD),
    .LEN        (LEN),
    .NXT        (NXT),
    .state      (state),
    .t_idx      (t_idx),
    .last       (last),
    .cycle_done (cycle_done),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Six-state instruction while EN alternates 0/1; holds on EN=0 edges
  task automatic toggle_run(input string tag);
    exp_idx = T2;
    for (int k = 0; k < 10; k++) begin
      EN = (k % 2 == 1);
      tick();
      if (EN) exp_idx = (exp_idx == T6) ? T1 : exp_idx + 1;
      chk({tag, "_idx"}, t_idx, exp_idx);
      chk({tag, "_cdone"}, cycle_done, (EN && exp_idx == T1));
    end
    EN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    CLR = 1'b1; EN = 1'b0; HLT = 1'b0; RUN = 1'b0;
    LEN_LD = 1'b0; LEN = '0; NXT = 1'b0;
    #3;
    chk("rst_state",  state, 6'b000001);
    chk("rst_idx",    t_idx, T1);
    chk("rst_halted", halted, 0);
    chk("rst_cdone",  cycle_done, 0);
    @(negedge CLK);
    CLR = 1'b0;
    EN  = 1'b1;

    // Free run, full length
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("run_state", state, 32'(1) << (k % 6));
      chk("run_cdone", cycle_done, (k % 6 == 0));
    end

    // Shortened instruction: length 4 loaded at T3
    chk("len4_at_t3", t_idx, T3);
    LEN_LD = 1'b1; LEN = 4'd4;
    #1;
    chk("len4_last_t3", last, 0);
    tick();
    LEN_LD = 1'b0;
    chk("len4_idx_t4", t_idx, T4);
    chk("len4_last_t4", last, 1);
    tick();
    chk("len4_wrap", t_idx, T1);
    chk("len4_cdone", cycle_done, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("full_idx", t_idx, k);
    end
    chk("full_last_t6", last, 1);
    chk("full_cdone_t6", cycle_done, 0);
    tick();
    chk("full_wrap", t_idx, T1);

    // Early end at T2
    tick();
    chk("nxt_at_t2", t_idx, T2);
    NXT = 1'b1;
    #1;
    chk("nxt_last", last, 1);
    tick();
    NXT = 1'b0;
    chk("nxt_idx", t_idx, T1);
    chk("nxt_cdone", cycle_done, 1);
    tick();
    chk("nxt_idx2", t_idx, T2);
    chk("nxt_cdone2", cycle_done, 0);

    // Halt at T5, hold for 10 edges, resume with RUN
    tick(); tick(); tick();
    chk("hlt_at_t5", t_idx, T5);
    HLT = 1'b1;
    tick();
    HLT = 1'b0;
    chk("hlt_idx", t_idx, T5);
    chk("hlt_flag", halted, 1);
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin HLT = 1'b1; RUN = 1'b1; end
      tick();
      HLT = 1'b0; RUN = 1'b0;
      chk("hold_idx", t_idx, T5);
      chk("hold_flag", halted, 1);
    end
    NXT = 1'b1;
    #1;
    chk("hold_last", last, 0);
    NXT = 1'b0;
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    chk("run_clear", halted, 0);
    chk("run_idx", t_idx, T5);
    tick();
    chk("resume_t6", t_idx, T6);
    tick();
    chk("resume_wrap", t_idx, T1);

    // Illegal lengths clamp to full length
    LEN_LD = 1'b1; LEN = 4'd0;
    #1;
    chk("clamp0_last", last, 0);
    tick();
    LEN_LD = 1'b0;
    chk("clamp0_idx", t_idx, T2);
    toggle_run("clamp0");
    LEN_LD = 1'b1; LEN = 4'd7;
    #1;
    chk("clamp7_last", last, 0);
    tick();
    LEN_LD = 1'b0;
    chk("clamp7_idx", t_idx, T2);
    toggle_run("clamp7");

    // Asynchronous reset mid-instruction while halted
    tick(); tick(); tick();
    chk("clr_at_t4", t_idx, T4);
    HLT = 1'b1;
    tick();
    HLT = 1'b0;
    chk("clr_pre_halt", halted, 1);
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_state", state, 6'b000001);
    chk("clr_idx", t_idx, T1);
    chk("clr_halted", halted, 0);
    @(negedge CLK);
    CLR = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("post_clr_idx", t_idx, T6);
    chk("post_clr_last", last, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_t_state_sequencer
`default_nettype wire
